// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: 2-FF sync, counter debounce, level plus press/release strobes.
// Optional auto-repeat of press_pulse while held is built when AUTOREPEAT_EN is defined.
module button_conditioner #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_DELAY      = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] rel_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_conditioner: all parameters must be >= 1");
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned HMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [HW-1:0] hc     [CHANNELS];
    logic [HW-1:0] hc_nxt [CHANNELS];
`else
    typedef enum logic {IDLE, HOLD} state_t;
`endif

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CW-1:0]       cnt       [CHANNELS];
    logic [CW-1:0]       cnt_nxt   [CHANNELS];
    state_t              state     [CHANNELS];
    state_t              state_nxt [CHANNELS];
    logic [CHANNELS-1:0] accept_c;
    logic [CHANNELS-1:0] level_nxt;
    logic [CHANNELS-1:0] press_nxt;
    logic [CHANNELS-1:0] rel_nxt;

    // A new synced value is accepted on the edge its persistence count completes.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            accept_c[i] = (s2[i] != level[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_comb begin
        level_nxt = level;
        press_nxt = '0;
        rel_nxt   = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_nxt[i]   = cnt[i];
            state_nxt[i] = state[i];
`ifdef AUTOREPEAT_EN
            hc_nxt[i]    = hc[i];
`endif
            if (s2[i] == level[i]) begin
                cnt_nxt[i] = '0;
            end else if (accept_c[i]) begin
                cnt_nxt[i]   = '0;
                level_nxt[i] = s2[i];
                press_nxt[i] = s2[i];
                rel_nxt[i]   = ~s2[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end

            // Release always wins over a due repeat so the two strobes never coincide.
            case (state[i])
                IDLE: begin
                    if (accept_c[i] && s2[i]) begin
                        state_nxt[i] = HOLD;
`ifdef AUTOREPEAT_EN
                        hc_nxt[i]    = '0;
`endif
                    end
                end
                HOLD: begin
                    if (accept_c[i] && !s2[i]) begin
                        state_nxt[i] = IDLE;
`ifdef AUTOREPEAT_EN
                        hc_nxt[i]    = '0;
                    end else if (hc[i] == HW'(HOLD_DELAY - 1)) begin
                        press_nxt[i] = 1'b1;
                        hc_nxt[i]    = '0;
                        state_nxt[i] = REPEAT;
                    end else begin
                        hc_nxt[i]    = hc[i] + HW'(1);
`endif
                    end
                end
`ifdef AUTOREPEAT_EN
                REPEAT: begin
                    if (accept_c[i] && !s2[i]) begin
                        state_nxt[i] = IDLE;
                        hc_nxt[i]    = '0;
                    end else if (hc[i] == HW'(REPEAT_PERIOD - 1)) begin
                        press_nxt[i] = 1'b1;
                        hc_nxt[i]    = '0;
                    end else begin
                        hc_nxt[i]    = hc[i] + HW'(1);
                    end
                end
`endif
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1          <= '0;
            s2          <= '0;
            level       <= '0;
            press_pulse <= '0;
            rel_pulse   <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i]   <= '0;
                state[i] <= IDLE;
`ifdef AUTOREPEAT_EN
                hc[i]    <= '0;
`endif
            end
        end else begin
            s1          <= btn_in;
            s2          <= s1;
            level       <= level_nxt;
            press_pulse <= press_nxt;
            rel_pulse   <= rel_nxt;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i]   <= cnt_nxt[i];
                state[i] <= state_nxt[i];
`ifdef AUTOREPEAT_EN
                hc[i]    <= hc_nxt[i];
`endif
            end
        end
    end

endmodule
